// File: rtl/weight_pattern_gen_pkg.sv
// Shared types and constants for the weight pattern generator.
// Optional feature macro used by this block: MATCH_COUNT_EN.
package weight_gen_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int WEIGHT_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CHECK,
        S_EMIT,
        S_NEXT,
        S_DONE
    } state_t;

endpackage

// File: rtl/weight_pattern_gen_if.sv
// Request/handshake bundle of the weight pattern generator.
// The generator side is the master, the consumer/requester side the slave.
// MATCH_COUNT_EN adds the match_count signal.
interface weight_pattern_gen_if
    import weight_gen_pkg::*;
    #(parameter int WIDTH = DEF_WIDTH);

    logic                start;
    logic [WEIGHT_W-1:0] weight;
    logic                ready;
    logic [WIDTH-1:0]    N_out;
    logic                valid;
    logic                busy;
    logic                done;
`ifdef MATCH_COUNT_EN
    logic [WIDTH-2:0]    match_count;
`endif

    modport master (
        input  start, weight, ready,
        output N_out, valid, busy, done
`ifdef MATCH_COUNT_EN
        , output match_count
`endif
    );

    modport slave (
        output start, weight, ready,
        input  N_out, valid, busy, done
`ifdef MATCH_COUNT_EN
        , input match_count
`endif
    );

endinterface

// File: rtl/weight_pattern_gen_datapath.sv
// Candidate counter plus shift-and-count ones counter for the generator.
// N_out is captured from the candidate at LOAD, so it is stable throughout EMIT.
module weight_gen_datapath
    import weight_gen_pkg::*;
    #(parameter int WIDTH = DEF_WIDTH)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                latch,
    input  logic                load,
    input  logic                shift,
    input  logic                inc,
    input  logic [WEIGHT_W-1:0] weight,
    output logic [WIDTH-1:0]    N_out,
    output logic                shift_zero,
    output logic                count_match,
    output logic                cand_last
);

    logic [WIDTH-1:0]    candidate;
    logic [WIDTH-1:0]    shift_reg;
    logic [WEIGHT_W-1:0] count;
    logic [WEIGHT_W-1:0] w_reg;

    // Candidate/weight registers and the shift-and-count ones counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            candidate <= '0;
            shift_reg <= '0;
            count     <= '0;
            w_reg     <= '0;
            N_out     <= '0;
        end else begin
            if (latch) begin
                w_reg     <= weight;
                candidate <= '0;
            end else if (inc) begin
                candidate <= candidate + {{(WIDTH-1){1'b0}}, 1'b1};
            end
            if (load) begin
                shift_reg <= candidate;
                count     <= '0;
                N_out     <= candidate;
            end else if (shift) begin
                count     <= count + {{(WEIGHT_W-1){1'b0}}, shift_reg[0]};
                shift_reg <= shift_reg >> 1;
            end
        end
    end

    assign shift_zero  = (shift_reg == '0);
    assign count_match = (count == w_reg);
    assign cand_last   = &candidate;

endmodule

// File: rtl/weight_pattern_gen.sv
// Enumerates, in ascending order, every WIDTH-bit value whose popcount equals
// the requested weight, offering each on a valid/ready handshake.
// Define MATCH_COUNT_EN to add the match_count output (accepted transfers).
module weight_pattern_gen
    import weight_gen_pkg::*;
    #(parameter int WIDTH = DEF_WIDTH)
(
    input logic                clk,
    input logic                rst,
    weight_pattern_gen_if.master bus
);

    state_t state;
    logic   valid_q;
    logic   busy_q;
    logic   done_q;
    logic   latch;
    logic   load;
    logic   shift;
    logic   inc;
    logic   shift_zero;
    logic   count_match;
    logic   cand_last;

    assign latch = (state == S_IDLE) && bus.start;
    assign load  = (state == S_LOAD);
    assign shift = (state == S_SHIFT) && !shift_zero;
    assign inc   = (state == S_NEXT) && !cand_last;

    weight_gen_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .latch       (latch),
        .load        (load),
        .shift       (shift),
        .inc         (inc),
        .weight      (bus.weight),
        .N_out       (bus.N_out),
        .shift_zero  (shift_zero),
        .count_match (count_match),
        .cand_last   (cand_last)
    );

    // Control FSM; valid/busy/done are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD:  state <= S_SHIFT;
                S_SHIFT: begin
                    if (shift_zero) state <= S_CHECK;
                end
                S_CHECK: begin
                    if (count_match) begin
                        valid_q <= 1'b1;
                        state   <= S_EMIT;
                    end else begin
                        state   <= S_NEXT;
                    end
                end
                S_EMIT: begin
                    if (bus.ready) begin
                        valid_q <= 1'b0;
                        state   <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (cand_last) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state  <= S_LOAD;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

`ifdef MATCH_COUNT_EN
    logic [WIDTH-2:0] match_count_q;

    // Counts accepted transfers of the current run; cleared on a new start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_count_q <= '0;
        end else if (latch) begin
            match_count_q <= '0;
        end else if ((state == S_EMIT) && bus.ready) begin
            match_count_q <= match_count_q + {{(WIDTH-2){1'b0}}, 1'b1};
        end
    end

    assign bus.match_count = match_count_q;
`endif

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Directed bench for weight_pattern_gen (WIDTH=8); honours MATCH_COUNT_EN.
module tb_weight_pattern_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    weight_pattern_gen_if #(.WIDTH(8)) bus ();

    weight_pattern_gen #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: smallest value >= from with popcount w, or -1.
    function automatic int next_match(input int from, input int w);
        for (int c = from; c < 256; c++) begin
            logic [7:0] cv;
            cv = c[7:0];
            if ($countones(cv) == w) return c;
        end
        return -1;
    endfunction

    task automatic run_enum(input logic [3:0] w, input int pulse_at,
                            output int n_xfer, output int first_valid,
                            output int seq_err, output logic [7:0] first_p,
                            output logic [7:0] second_p, output logic [7:0] last_p,
                            output int timed_out, output int busy_err,
                            output int last_xfer_cyc, output int done_cyc);
        int  cyc;
        int  exp_next;
        bit  pulsed;
        n_xfer = 0; first_valid = -1; seq_err = 0; first_p = '0; second_p = '0;
        last_p = '0; timed_out = 1; busy_err = 0; pulsed = 0;
        last_xfer_cyc = -1; done_cyc = -1;
        exp_next = next_match(0, int'(w));
        @(negedge clk);
        bus.start = 1'b1; bus.weight = w; bus.ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 6000) begin
            bus.start = 1'b0;
            if (pulse_at >= 0 && !pulsed && n_xfer == pulse_at) begin
                bus.start  = 1'b1;
                bus.weight = 4'd1;
                pulsed     = 1;
            end
            if (bus.done) begin
                timed_out = 0;
                done_cyc  = cyc;
                break;
            end
            if (!bus.busy) busy_err++;
            if (bus.valid && first_valid < 0) first_valid = cyc;
            if (bus.valid && bus.ready) begin
                if (exp_next < 0 || bus.N_out != exp_next[7:0]) seq_err++;
                if (n_xfer == 0) first_p = bus.N_out;
                if (n_xfer == 1) second_p = bus.N_out;
                last_p = bus.N_out;
                last_xfer_cyc = cyc;
                n_xfer++;
                exp_next = (exp_next < 0) ? -1 : next_match(exp_next + 1, int'(w));
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        if (exp_next >= 0) seq_err++;
    endtask

    task automatic wait_valid(output int ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Checks common to the end of every run: done seen, busy low in DONE,
    // done lasting one cycle.
    task automatic check_end(input string tag, input int timed_out);
        check_eq({tag, "_done_seen"}, timed_out, 0);
        check_eq({tag, "_busy_in_done"}, bus.busy, 1'b0);
        @(negedge clk);
        check_eq({tag, "_done_one_cycle"}, bus.done, 1'b0);
        check_eq({tag, "_valid_after"}, bus.valid, 1'b0);
    endtask

    initial begin
        int n, fv, se, to, be, lx, dc, ok, stab_err;
        logic [7:0] p0, p1, pl;

        bus.start = 1'b0; bus.weight = 4'd0; bus.ready = 1'b0;
        #1;
        check_eq("rst_valid", bus.valid, 1'b0);
        check_eq("rst_busy",  bus.busy,  1'b0);
        check_eq("rst_done",  bus.done,  1'b0);
        check_eq("rst_nout",  bus.N_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // weight=4, ready tied high
        run_enum(4'd4, -1, n, fv, se, p0, p1, pl, to, be, lx, dc);
        check_eq("w4_count",  n,  70);
        check_eq("w4_first",  p0, 8'h0F);
        check_eq("w4_second", p1, 8'h17);
        check_eq("w4_last",   pl, 8'hF0);
        check_eq("w4_seq",    se, 0);
        check_eq("w4_busy",   be, 0);
        check_end("w4", to);
`ifdef MATCH_COUNT_EN
        check_eq("w4_match_count", bus.match_count, 70);
`endif

        // weight=0: single all-zero pattern, valid in cycle 4
        run_enum(4'd0, -1, n, fv, se, p0, p1, pl, to, be, lx, dc);
        check_eq("w0_count",  n,  1);
        check_eq("w0_first",  p0, 8'h00);
        check_eq("w0_latency", fv, 4);
        check_eq("w0_seq",    se, 0);
        check_end("w0", to);

        // weight=8: only 0xFF, done two cycles after the transfer (NEXT, DONE)
        run_enum(4'd8, -1, n, fv, se, p0, p1, pl, to, be, lx, dc);
        check_eq("w8_count", n,  1);
        check_eq("w8_first", p0, 8'hFF);
        check_eq("w8_done_gap", dc - lx, 2);
        check_end("w8", to);

        // weight=9 exceeds WIDTH: no valid at all, done still pulses
        run_enum(4'd9, -1, n, fv, se, p0, p1, pl, to, be, lx, dc);
        check_eq("w9_count", n, 0);
        check_eq("w9_no_valid", fv, -1);
        check_end("w9", to);
`ifdef MATCH_COUNT_EN
        check_eq("w9_match_count", bus.match_count, 0);
`endif

        // start/weight disturbed mid-run must be ignored
        run_enum(4'd4, 10, n, fv, se, p0, p1, pl, to, be, lx, dc);
        check_eq("pulse_count", n, 70);
        check_eq("pulse_seq",   se, 0);
        check_end("pulse", to);

        // backpressure: 0x0F held for 5 cycles, then 0x17 only after acceptance
        @(negedge clk);
        bus.start = 1'b1; bus.weight = 4'd4; bus.ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(ok);
        check_eq("bp_valid_seen", ok, 1);
        check_eq("bp_first", bus.N_out, 8'h0F);
        stab_err = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!bus.valid || bus.N_out != 8'h0F) stab_err++;
        end
        check_eq("bp_stable", stab_err, 0);
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
        check_eq("bp_valid_drop", bus.valid, 1'b0);
        wait_valid(ok);
        check_eq("bp_second_seen", ok, 1);
        check_eq("bp_second", bus.N_out, 8'h17);

        // reset in EMIT while 0x0F is offered
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b1; bus.weight = 4'd4; bus.ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(ok);
        check_eq("rst_emit_seen", ok, 1);
        check_eq("rst_emit_nout", bus.N_out, 8'h0F);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_emit_valid", bus.valid, 1'b0);
        check_eq("rst_emit_busy",  bus.busy,  1'b0);
        check_eq("rst_emit_done",  bus.done,  1'b0);
        @(negedge clk);
        check_eq("rst_emit_no_done", bus.done, 1'b0);
        rst = 1'b0;
        run_enum(4'd4, -1, n, fv, se, p0, p1, pl, to, be, lx, dc);
        check_eq("rerun_first", p0, 8'h0F);
        check_eq("rerun_count", n, 70);
        check_end("rerun", to);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
